// File: rtl/capiano_pkg.sv
// Shared scanner state, RGB333 field layout and luma helper for the capiano capture path.
package capiano_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SCAN,
    ST_EVAL,
    ST_UPDATE
  } scan_state_t;

  localparam int unsigned PIX_W  = 9;
  localparam int unsigned R_HI   = 8;
  localparam int unsigned R_LO   = 6;
  localparam int unsigned G_HI   = 5;
  localparam int unsigned G_LO   = 3;
  localparam int unsigned B_HI   = 2;
  localparam int unsigned B_LO   = 0;
  localparam int unsigned LUMA_W = 5;

  // r+g+b of an RGB333 pixel, zero-extended to 5 bits (max 21)
  function automatic logic [LUMA_W-1:0] luma_sum(input logic [PIX_W-1:0] pix);
    return LUMA_W'(pix[R_HI:R_LO]) + LUMA_W'(pix[G_HI:G_LO]) + LUMA_W'(pix[B_HI:B_LO]);
  endfunction

endpackage

// File: rtl/key_debouncer.sv
// Per-key hysteresis decision and committed pressed state.
// KEY_SCANNER_DEBOUNCE_EN adds a multi-frame agree counter before a state change commits.
module key_debouncer #(
  parameter int unsigned CNT_W           = 14,
  parameter int unsigned COUNT_TH        = 2000,
  parameter int unsigned DEBOUNCE_FRAMES = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [CNT_W-1:0] cnt,
  input  logic             eval,
  output logic             pressed
);

  logic raw_c;

  // Press at the full threshold, release only below half of it
  always_comb begin
    raw_c = pressed;
    if (!pressed && (32'(cnt) >= COUNT_TH))
      raw_c = 1'b1;
    if (pressed && (32'(cnt) < (COUNT_TH >> 1)))
      raw_c = 1'b0;
  end

`ifdef KEY_SCANNER_DEBOUNCE_EN
  localparam int unsigned AGREE_W = (DEBOUNCE_FRAMES > 1) ? $clog2(DEBOUNCE_FRAMES + 1) : 1;

  logic [AGREE_W-1:0] agree;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pressed <= 1'b0;
      agree   <= '0;
    end else if (eval) begin
      if (raw_c == pressed) begin
        agree <= '0;
      end else if ((32'(agree) + 1) >= DEBOUNCE_FRAMES) begin
        pressed <= raw_c;
        agree   <= '0;
      end else begin
        agree <= agree + AGREE_W'(1);
      end
    end
  end
`else
  logic unused_debounce;
  assign unused_debounce = ^32'(DEBOUNCE_FRAMES);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      pressed <= 1'b0;
    else if (eval)
      pressed <= raw_c;
  end
`endif

endmodule

// File: rtl/key_scanner.sv
// Counts dark pixels per key region in a horizontal band once per frame and publishes a pressed-key bitmap.
// KEY_SCANNER_DEBOUNCE_EN enables multi-frame debounce inside each key_debouncer.
module key_scanner
  import capiano_pkg::*;
#(
  parameter int unsigned H_RES           = 640,
  parameter int unsigned V_RES           = 480,
  parameter int unsigned KEYS            = 8,
  parameter int unsigned BAND_TOP        = 360,
  parameter int unsigned BAND_BOT        = 479,
  parameter int unsigned LUMA_TH         = 9,
  parameter int unsigned COUNT_TH        = 2000,
  parameter int unsigned DEBOUNCE_FRAMES = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             frame_start,
  input  logic             pix_valid,
  input  logic [PIX_W-1:0] pix_data,
  output logic [KEYS-1:0]  key_mask,
  output logic             key_event,
  output logic [15:0]      debug_out
);

  localparam int unsigned KEY_W = H_RES / KEYS;
  localparam int unsigned CNT_W = $clog2(KEY_W * (BAND_BOT - BAND_TOP + 1) + 1);
  localparam int unsigned X_W   = (H_RES > 1) ? $clog2(H_RES) : 1;
  localparam int unsigned Y_W   = (V_RES > 1) ? $clog2(V_RES) : 1;
  localparam int unsigned SUB_W = (KEY_W > 1) ? $clog2(KEY_W) : 1;
  localparam int unsigned K_W   = (KEYS > 1) ? $clog2(KEYS) : 1;

  localparam logic [X_W-1:0]   X_LAST   = X_W'(H_RES - 1);
  localparam logic [Y_W-1:0]   Y_LAST   = Y_W'(V_RES - 1);
  localparam logic [SUB_W-1:0] SUB_LAST = SUB_W'(KEY_W - 1);
  localparam logic [K_W-1:0]   K_LAST   = K_W'(KEYS - 1);

  scan_state_t      state;
  logic [X_W-1:0]   x;
  logic [Y_W-1:0]   y;
  logic [SUB_W-1:0] sub;
  logic [K_W-1:0]   key;
  logic [K_W-1:0]   eval_idx;
  logic [CNT_W-1:0] cnt [KEYS];
  logic [7:0]       dropped_frames;
  logic [7:0]       frames_done;
  logic [KEYS-1:0]  committed;
  logic [KEYS-1:0]  eval_c;
  logic             in_band_c;
  logic             dark_c;

  assign in_band_c = (32'(y) >= BAND_TOP) && (32'(y) <= BAND_BOT);
  assign dark_c    = 32'(luma_sum(pix_data)) < LUMA_TH;
  assign debug_out = {dropped_frames, frames_done};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= ST_IDLE;
      x              <= '0;
      y              <= '0;
      sub            <= '0;
      key            <= '0;
      eval_idx       <= '0;
      key_mask       <= '0;
      key_event      <= 1'b0;
      dropped_frames <= '0;
      frames_done    <= '0;
      for (int i = 0; i < int'(KEYS); i++) cnt[i] <= '0;
    end else begin
      key_event <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (frame_start) begin
            state <= ST_SCAN;
            x     <= '0;
            y     <= '0;
            sub   <= '0;
            key   <= '0;
            for (int i = 0; i < int'(KEYS); i++) cnt[i] <= '0;
          end
        end
        ST_SCAN: begin
          // A new frame_start abandons the partial frame; its pixel is dropped too
          if (frame_start) begin
            dropped_frames <= dropped_frames + 8'd1;
            x              <= '0;
            y              <= '0;
            sub            <= '0;
            key            <= '0;
            for (int i = 0; i < int'(KEYS); i++) cnt[i] <= '0;
          end else if (pix_valid) begin
            if (in_band_c && dark_c)
              cnt[key] <= cnt[key] + CNT_W'(1);
            if (x == X_LAST) begin
              x   <= '0;
              sub <= '0;
              key <= '0;
              if (y == Y_LAST) begin
                state    <= ST_EVAL;
                eval_idx <= '0;
              end else begin
                y <= y + Y_W'(1);
              end
            end else begin
              x <= x + X_W'(1);
              if (sub == SUB_LAST) begin
                sub <= '0;
                key <= key + K_W'(1);
              end else begin
                sub <= sub + SUB_W'(1);
              end
            end
          end
        end
        ST_EVAL: begin
          if (frame_start)
            dropped_frames <= dropped_frames + 8'd1;
          if (eval_idx == K_LAST)
            state <= ST_UPDATE;
          else
            eval_idx <= eval_idx + K_W'(1);
        end
        ST_UPDATE: begin
          if (frame_start)
            dropped_frames <= dropped_frames + 8'd1;
          key_mask    <= committed;
          key_event   <= (committed != key_mask);
          frames_done <= frames_done + 8'd1;
          state       <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // One debouncer per key, strobed in its own EVAL cycle
  for (genvar i = 0; i < int'(KEYS); i++) begin : g_key
    assign eval_c[i] = (state == ST_EVAL) && (eval_idx == K_W'(i));

    key_debouncer #(
      .CNT_W           (CNT_W),
      .COUNT_TH        (COUNT_TH),
      .DEBOUNCE_FRAMES (DEBOUNCE_FRAMES)
    ) u_deb (
      .clk     (clk),
      .rst     (rst),
      .cnt     (cnt[i]),
      .eval    (eval_c[i]),
      .pressed (committed[i])
    );
  end

endmodule

// File: tb/tb_key_scanner.sv
// Directed frame-level bench for key_scanner on a reduced 32x6 image, 8 keys of 4 columns, band rows 3..5.
// Expectations for both the plain and KEY_SCANNER_DEBOUNCE_EN builds are held side by side.
`timescale 1ns/1ps
module tb_key_scanner;

  localparam int H  = 32;
  localparam int V  = 6;
  localparam int K  = 8;
  localparam int BT = 3;
  localparam int BB = 5;
  localparam int KW = H / K;
  localparam logic [8:0] DARK_PIX  = 9'b011_011_010;  // luma 8
  localparam logic [8:0] LIGHT_PIX = 9'b011_011_011;  // luma 9

`ifdef KEY_SCANNER_DEBOUNCE_EN
  localparam bit DB = 1'b1;
`else
  localparam bit DB = 1'b0;
`endif

  typedef logic [7:0][3:0] counts_t;
  typedef struct {
    counts_t    dk;
    bit         white;
    logic [7:0] mask_plain;
    logic [7:0] mask_db;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        frame_start;
  logic        pix_valid;
  logic [8:0]  pix_data;
  logic [7:0]  key_mask;
  logic        key_event;
  logic [15:0] debug_out;

  int         n_vec = 0;
  int         n_err = 0;
  logic [7:0] prev_mask = 8'h00;
  logic [7:0] exp_frames = 8'h00;
  logic [7:0] exp_dropped = 8'h00;
  vec_t       tbl [17];

  key_scanner #(
    .H_RES(H), .V_RES(V), .KEYS(K), .BAND_TOP(BT), .BAND_BOT(BB),
    .LUMA_TH(9), .COUNT_TH(8), .DEBOUNCE_FRAMES(3)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .frame_start (frame_start),
    .pix_valid   (pix_valid),
    .pix_data    (pix_data),
    .key_mask    (key_mask),
    .key_event   (key_event),
    .debug_out   (debug_out)
  );

  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Out-of-band rows are black; in band, the first dk[key] pixels of the region (row-major) are dark
  function automatic logic [8:0] pix_at(input counts_t dk, input bit white, input int idx);
    int x, y, loc;
    x = idx % H;
    y = idx / H;
    if (white) return 9'h1FF;
    if (y < BT || y > BB) return 9'h000;
    loc = (y - BT) * KW + (x % KW);
    return (loc < int'(dk[x / KW])) ? DARK_PIX : LIGHT_PIX;
  endfunction

  // frame_start carries a dark pixel that must be ignored; every 7th cycle is an idle gap
  task automatic send_pixels(input counts_t dk, input bit white, input int n);
    int idx;
    int g;
    idx = 0;
    g   = 0;
    @(negedge clk);
    frame_start = 1'b1;
    pix_valid   = 1'b1;
    pix_data    = 9'h000;
    while (idx < n) begin
      @(negedge clk);
      frame_start = 1'b0;
      if (g % 7 == 6) begin
        pix_valid = 1'b0;
        pix_data  = 9'h000;
      end else begin
        pix_valid = 1'b1;
        pix_data  = pix_at(dk, white, idx);
        idx++;
      end
      g++;
    end
  endtask

  // Called right after the last pixel is driven; that pixel is accepted in cycle T
  task automatic finish_frame(input string tag, input logic [7:0] exp_mask, input int fs_at);
    bit bad;
    logic exp_evt;
    bad = 1'b0;
    for (int j = 1; j <= K + 1; j++) begin
      @(negedge clk);
      if (key_event !== 1'b0 || key_mask !== prev_mask) bad = 1'b1;
      frame_start = (j == fs_at);
      pix_valid   = 1'b1;
      pix_data    = 9'h000;
    end
    check($sformatf("%s hold", tag), 32'(bad), 32'd0);
    @(negedge clk);
    frame_start = 1'b0;
    pix_valid   = 1'b0;
    exp_frames  = exp_frames + 8'd1;
    exp_evt     = (exp_mask != prev_mask);
    check($sformatf("%s mask", tag), 32'(key_mask), 32'(exp_mask));
    check($sformatf("%s event", tag), 32'(key_event), 32'(exp_evt));
    check($sformatf("%s debug", tag), 32'(debug_out), 32'({exp_dropped, exp_frames}));
    prev_mask = exp_mask;
    @(negedge clk);
    check($sformatf("%s event_clear", tag), 32'(key_event), 32'd0);
  endtask

  initial begin
    rst         = 1'b1;
    frame_start = 1'b0;
    pix_valid   = 1'b0;
    pix_data    = 9'h000;

    tbl[0]  = '{counts_t'(32'h0000_0000), 1'b1, 8'h00, 8'h00};
    tbl[1]  = '{counts_t'(32'h0000_0C00), 1'b0, 8'h04, 8'h00};
    tbl[2]  = '{counts_t'(32'h0000_0C00), 1'b0, 8'h04, 8'h00};
    tbl[3]  = '{counts_t'(32'h0000_0C00), 1'b0, 8'h04, 8'h04};
    tbl[4]  = '{counts_t'(32'h0000_0600), 1'b0, 8'h04, 8'h04};
    tbl[5]  = '{counts_t'(32'h0000_0600), 1'b0, 8'h04, 8'h04};
    tbl[6]  = '{counts_t'(32'h0000_0600), 1'b0, 8'h04, 8'h04};
    tbl[7]  = '{counts_t'(32'h0000_0300), 1'b0, 8'h00, 8'h04};
    tbl[8]  = '{counts_t'(32'h0000_0300), 1'b0, 8'h00, 8'h04};
    tbl[9]  = '{counts_t'(32'h0000_0600), 1'b0, 8'h00, 8'h04};
    tbl[10] = '{counts_t'(32'h0000_0000), 1'b0, 8'h00, 8'h04};
    tbl[11] = '{counts_t'(32'h0000_0000), 1'b0, 8'h00, 8'h04};
    tbl[12] = '{counts_t'(32'h0000_0000), 1'b0, 8'h00, 8'h00};
    tbl[13] = '{counts_t'(32'hC0C0_0078), 1'b0, 8'hA1, 8'h00};
    tbl[14] = '{counts_t'(32'hC0C0_0078), 1'b0, 8'hA1, 8'h00};
    tbl[15] = '{counts_t'(32'hC0C0_0078), 1'b0, 8'hA1, 8'hA1};
    tbl[16] = '{counts_t'(32'hC030_0084), 1'b0, 8'h83, 8'hA1};

    repeat (3) @(negedge clk);
    check("reset key_mask", 32'(key_mask), 32'd0);
    check("reset key_event", 32'(key_event), 32'd0);
    check("reset debug_out", 32'(debug_out), 32'd0);
    rst = 1'b0;

    for (int i = 0; i < 17; i++) begin
      send_pixels(tbl[i].dk, tbl[i].white, H * V);
      finish_frame($sformatf("frame%0d", i + 1), DB ? tbl[i].mask_db : tbl[i].mask_plain, 0);
    end

    // Abandoned partial frame of black pixels, then restart: partial counts must be discarded
    send_pixels(counts_t'(32'hCCCC_CCCC), 1'b0, 150);
    exp_dropped = exp_dropped + 8'd1;
    send_pixels(counts_t'(32'hC030_0084), 1'b0, H * V);
    finish_frame("restart", DB ? 8'hA1 : 8'h83, 0);

    // frame_start during EVAL is counted as dropped and does not start a scan
    send_pixels(counts_t'(32'hC030_0084), 1'b0, H * V);
    exp_dropped = exp_dropped + 8'd1;
    finish_frame("eval_fs", 8'h83, 3);

    // Pixels while IDLE must not start or complete a frame
    for (int i = 0; i < H * V; i++) begin
      @(negedge clk);
      pix_valid = 1'b1;
      pix_data  = 9'h000;
    end
    @(negedge clk);
    pix_valid = 1'b0;
    repeat (K + 4) @(negedge clk);
    check("idle_ignore debug", 32'(debug_out), 32'({exp_dropped, exp_frames}));
    check("idle_ignore mask", 32'(key_mask), 32'(prev_mask));

    // Asynchronous reset in the middle of a scan
    send_pixels(counts_t'(32'h0000_0C00), 1'b0, 120);
    @(negedge clk);
    pix_valid = 1'b0;
    rst       = 1'b1;
    #1;
    check("midscan_rst key_mask", 32'(key_mask), 32'd0);
    check("midscan_rst debug_out", 32'(debug_out), 32'd0);
    check("midscan_rst key_event", 32'(key_event), 32'd0);
    @(negedge clk);
    rst         = 1'b0;
    prev_mask   = 8'h00;
    exp_frames  = 8'h00;
    exp_dropped = 8'h00;
    for (int i = 0; i < 3; i++) begin
      send_pixels(counts_t'(32'h0000_0C00), 1'b0, H * V);
      finish_frame($sformatf("post_rst%0d", i + 1), (DB && i < 2) ? 8'h00 : 8'h04, 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/key_scanner.md
# key_scanner

Downstream consumer of the camera capture path. Watches the 9-bit RGB333 pixel stream as it is written into frame memory and splits a horizontal band of the image into equal-width piano-key regions. Once per frame it counts dark pixels per region and, with hysteresis and optional multi-frame debounce, produces a pressed-key bitmap. The bitmap feeds the tone generator and the debug LEDs.

## Interface
- `H_RES`, 640: pixels per line; must be a multiple of `KEYS`.
- `V_RES`, 480: lines per frame.
- `KEYS`, 8: number of key regions.
- `BAND_TOP`, 360: first line of the key band, inclusive.
- `BAND_BOT`, 479: last line of the key band, inclusive.
- `LUMA_TH`, 9: a pixel is dark if r+g+b < `LUMA_TH`.
- `COUNT_TH`, 2000: dark-pixel count at or above which a key is pressed.
- `DEBOUNCE_FRAMES`, 3: consecutive agreeing frames needed to change a key.
- `clk` in 1: sole clock, the camera memory clock domain.
- `rst` in 1: asynchronous, active-high reset.
- `frame_start` in 1: one-cycle pulse; the next valid pixel is (0,0).
- `pix_valid` in 1: `pix_data` carries a pixel this cycle.
- `pix_data` in 9: {r[2:0], g[2:0], b[2:0]}.
- `key_mask` out `KEYS`: bit i set means key i is pressed.
- `key_event` out 1: one-cycle pulse when `key_mask` changes.
- `debug_out` out 16: {dropped_frames[7:0], frames_done[7:0]}; both wrap.

## Operation
- **States**
  - IDLE: wait for `frame_start`.
  - SCAN: accept pixels.
  - EVAL: evaluate one key per cycle.
  - UPDATE: commit results.
- **Transitions**
  - IDLE→SCAN on `frame_start`. Clears x, y and all per-key counters.
  - In SCAN, each `pix_valid` advances x. When x wraps at `H_RES`-1, y increments.
  - After pixel (`H_RES`-1, `V_RES`-1) is accepted, SCAN→EVAL.
  - EVAL lasts exactly `KEYS` cycles, key i in EVAL cycle i. Then UPDATE for one cycle, then IDLE.
- **Key index:** tracked with a column sub-counter that rolls every `H_RES`/`KEYS` pixels. No divider.
- **Counting:** a pixel increments `cnt[key]` only if y is in [`BAND_TOP`, `BAND_BOT`] and r+g+b < `LUMA_TH`. The sum is 5 bits, zero-extended.
- **Counter width:** clog2((`H_RES`/`KEYS`)·(`BAND_BOT`-`BAND_TOP`+1)+1). Overflow is impossible by construction.
- **Hysteresis (raw decision):**
  - A released key becomes raw-pressed when cnt ≥ `COUNT_TH`.
  - A pressed key becomes raw-released when cnt < `COUNT_TH`/2 (integer shift).
  - Otherwise raw equals the current state.
- **Boundary cases:**
  - `frame_start` during SCAN restarts the frame. Counts are discarded and `dropped_frames` increments.
  - `frame_start` during EVAL or UPDATE is ignored and `dropped_frames` increments; that frame is not scanned.
  - `pix_valid` outside SCAN is ignored.
  - `frame_start` and `pix_valid` in the same cycle: the pixel is ignored.
- **Reset:** asynchronous; any state→IDLE. Counters clear. Outputs: `key_mask`=0, `key_event`=0, `debug_out`=0.

## Timing
- The last pixel is accepted in cycle T. EVAL spans T+1..T+`KEYS`. UPDATE is at T+`KEYS`+1.
- `key_mask` takes its new value and `key_event` pulses in cycle T+`KEYS`+2, registered.
- `key_event` is high for exactly 1 cycle and only if at least one bit changed.
- `frames_done` increments in the same cycle as the `key_mask` update.
- `key_mask` is stable between updates.

## Configuration
- `KEY_SCANNER_DEBOUNCE_EN` defined: each key keeps an agree counter.
  - The counter increments when raw ≠ committed state, capped at `DEBOUNCE_FRAMES`.
  - It resets to 0 when raw = committed state.
  - The committed state flips when the counter reaches `DEBOUNCE_FRAMES`; the counter then clears.
- Not defined: the raw decision commits directly each frame, and `DEBOUNCE_FRAMES` is unused.

## Structure
- **Shared package `capiano_pkg`:**
  - scanner state enum (IDLE/SCAN/EVAL/UPDATE);
  - RGB333 field-slicing constants;
  - luma-sum function.
- **Sub-module `key_debouncer`** (one instance per key, via generate):
  - hysteresis compare plus optional debounce counter;
  - inputs: cnt, eval strobe;
  - output: committed state.

## Test plan
- **White frame:** all pixels 9'h1FF. Expect `key_mask`=0, no `key_event`, `frames_done`=1.
- **Black key 2 band** (x 160..239, y 360..479 = 9600 dark pixels), with debounce enabled: `key_mask` stays 0 for frames 1–2, becomes 8'h04 at frame 3, and `key_event` pulses once at T+10 (`KEYS`=8).
- **Hysteresis:** key 2 pressed, then frames with 1500 dark pixels keep it pressed. Frames with 900 dark pixels release it after 3 frames.
- **Threshold edge:** exactly 2000 dark pixels in key 0 presses it; 1999 does not.
- **Disrupted frames:** `frame_start` mid-frame at pixel 100000 makes `dropped_frames`=1 with no mask change. A `frame_start` during EVAL is ignored and `dropped_frames`=2.
- **Reset mid-SCAN:** `rst` pulsed mid-SCAN gives `key_mask`=0 and `debug_out`=0 immediately. The next full black frame still needs 3 frames to press (debounce enabled).
